// File: rtl/lsu_dmem_master_if.sv
// Bus bundle between the load/store unit and its neighbours.
// Request side : req_valid/req_ready handshake plus req_we, req_funct3,
//                req_addr and req_wdata from the execute stage.
// Response side: rsp_valid pulse with rsp_rdata and rsp_fault.
// Memory side  : mem_a, mem_rde, mem_we, mem_wd towards the data memory,
//                mem_rd (combinational read data) back from it.
// The master modport is the LSU; the slave modport is the core + memory.
interface lsu_dmem_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic [31:0] mem_a;
    logic        mem_rde;
    logic [31:0] mem_rd;
    logic        mem_we;
    logic [31:0] mem_wd;

    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault,
               mem_a, mem_rde, mem_we, mem_wd
    );

    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rd,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault,
               mem_a, mem_rde, mem_we, mem_wd
    );
endinterface

// File: rtl/lsu_dmem_master.sv
// Load/store unit between the execute stage and a word-wide, byte-addressed
// data memory. One request at a time; sub-word stores are done as a
// read-modify-write because the memory always writes a whole word.
// Faulting requests (illegal width, misaligned, out of range) respond at
// once and never touch memory.
// Ports:
//   clk   - clock, all state changes on the rising edge
//   rst_n - synchronous active-low reset
//   bus   - lsu_dmem_master_if.master: request, response and memory ports
// Parameter:
//   MEM_SIZE - memory depth in 32-bit words
module lsu_dmem_master #(
    parameter int MEM_SIZE = 4096
) (
    input  logic                    clk,
    input  logic                    rst_n,
    lsu_dmem_master_if.master       bus
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        READ,
        WRITE,
        RESP
    } state_t;

    localparam logic [32:0] LAST_ADDR = 33'(MEM_SIZE * 4 - 1);

    state_t      state;
    state_t      next_state;

    logic [31:0] addr_q;
    logic        we_q;
    logic [2:0]  f3_q;
    logic        fault_q;
    logic [31:0] merge_q;
    logic [31:0] rdata_q;

    logic [2:0]  req_size;
    logic        req_illegal;
    logic        req_misaligned;
    logic        req_out_of_range;
    logic        req_fault;
    logic [32:0] req_last_byte;

    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_val;
    logic [31:0] merge_val;

    // Fault classification of the request currently on the bus. The last
    // byte is computed one bit wider so addresses near 2^32 cannot wrap
    // around into the legal range.
    always_comb begin
        req_size = 3'd4;
        case (bus.req_funct3[1:0])
            2'b00:   req_size = 3'd1;
            2'b01:   req_size = 3'd2;
            default: req_size = 3'd4;
        endcase
        if (bus.req_we) begin
            req_illegal = !(bus.req_funct3 inside {3'b000, 3'b001, 3'b010});
        end else begin
            req_illegal = !(bus.req_funct3 inside {3'b000, 3'b001, 3'b010,
                                                   3'b100, 3'b101});
        end
        req_misaligned   = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                           ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
        req_last_byte    = {1'b0, bus.req_addr} + {30'b0, req_size} - 33'd1;
        req_out_of_range = req_last_byte > LAST_ADDR;
        req_fault        = req_illegal || req_misaligned || req_out_of_range;
    end

    // Load lane selection and extension from the word the memory returns.
    always_comb begin
        load_byte = bus.mem_rd[7:0];
        case (addr_q[1:0])
            2'b00: load_byte = bus.mem_rd[7:0];
            2'b01: load_byte = bus.mem_rd[15:8];
            2'b10: load_byte = bus.mem_rd[23:16];
            2'b11: load_byte = bus.mem_rd[31:24];
        endcase
        load_half = addr_q[1] ? bus.mem_rd[31:16] : bus.mem_rd[15:0];
        case (f3_q)
            3'b000:  load_val = {{24{load_byte[7]}}, load_byte};
            3'b001:  load_val = {{16{load_half[15]}}, load_half};
            3'b100:  load_val = {24'b0, load_byte};
            3'b101:  load_val = {16'b0, load_half};
            default: load_val = bus.mem_rd;
        endcase
    end

    // Read-modify-write merge. Until READ completes, merge_q still holds the
    // right-aligned store data, so the new lane comes from its low bits.
    always_comb begin
        merge_val = bus.mem_rd;
        if (f3_q[1:0] == 2'b00) begin
            merge_val[{addr_q[1:0], 3'b000} +: 8] = merge_q[7:0];
        end else begin
            merge_val[{addr_q[1], 4'b0000} +: 16] = merge_q[15:0];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: a faulting request goes straight to RESP, word
    // stores skip the read phase, sub-word stores read first.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (req_fault) begin
                        next_state = RESP;
                    end else if (!bus.req_we) begin
                        next_state = LOAD;
                    end else if (bus.req_funct3[1:0] == 2'b10) begin
                        next_state = WRITE;
                    end else begin
                        next_state = READ;
                    end
                end
            end
            LOAD:    next_state = RESP;
            READ:    next_state = WRITE;
            WRITE:   next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Request latches, load result and merge register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            fault_q <= 1'b0;
            merge_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        addr_q  <= bus.req_addr;
                        we_q    <= bus.req_we;
                        f3_q    <= bus.req_funct3;
                        fault_q <= req_fault;
                        merge_q <= bus.req_wdata;
                        rdata_q <= '0;
                    end
                end
                LOAD:    rdata_q <= load_val;
                READ:    merge_q <= merge_val;
                default: ;
            endcase
        end
    end

    // Outputs. Memory strobes are gated by rst_n so a WRITE cycle that
    // coincides with reset cannot commit.
    assign bus.req_ready = (state == IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_fault = (state == RESP) && fault_q;
    assign bus.rsp_rdata = ((state == RESP) && !we_q && !fault_q) ? rdata_q : 32'h0;
    assign bus.mem_a     = {addr_q[31:2], 2'b00};
    assign bus.mem_rde   = rst_n && ((state == LOAD) || (state == READ));
    assign bus.mem_we    = rst_n && (state == WRITE);
    assign bus.mem_wd    = (state == WRITE) ? merge_q : 32'h0;

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Self-checking bench for lsu_dmem_master. A word-wide memory model answers
// the DUT; a byte-array reference model derives every expected response,
// latency and memory write directly from the load/store rules.
module tb_lsu_dmem_master;

    localparam int MEM_SIZE = 4096;
    localparam int BYTES    = MEM_SIZE * 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    lsu_dmem_master_if ifc();

    lsu_dmem_master #(.MEM_SIZE(MEM_SIZE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.master)
    );

    logic [31:0] mem    [MEM_SIZE] = '{default: 32'h0};
    logic [7:0]  refMem [BYTES]    = '{default: 8'h00};

    int          checks = 0;
    int          errors = 0;
    logic [31:0] lastRdata;

    // Combinational read port of the memory under the DUT.
    always_comb begin
        if (ifc.mem_a < 32'(BYTES)) ifc.mem_rd = mem[ifc.mem_a[13:2]];
        else                        ifc.mem_rd = 32'h0;
    end

    // Memory commits whole words on the rising edge while mem_we is high.
    always @(posedge clk) begin
        if (ifc.mem_we && (ifc.mem_a < 32'(BYTES))) mem[ifc.mem_a[13:2]] <= ifc.mem_wd;
    end

    // Watchdog so the run always ends.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Reference model: byte-addressed memory, width/alignment/range rules,
    // and the response cycle counted from the accept edge.
    task automatic refAccess(input logic we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output logic fault, output logic [31:0] rdata,
                             output int lat, output int writes,
                             output logic [31:0] wword);
        int          size;
        bit          legal;
        longint      lastByte;
        logic [31:0] val;
        logic [31:0] base;
        legal    = we ? (f3 <= 3'd2)
                      : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        size     = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
        lastByte = longint'(addr) + longint'(size) - 1;
        fault    = !legal || ((addr % size) != 0) || (lastByte > longint'(BYTES - 1));
        rdata    = 32'h0;
        writes   = 0;
        wword    = 32'h0;
        if (fault) begin
            lat = 1;
        end else if (!we) begin
            val = 32'h0;
            for (int i = 0; i < size; i++) val = val | ({24'b0, refMem[addr + i]} << (8 * i));
            case (f3)
                3'd0:    rdata = {{24{val[7]}}, val[7:0]};
                3'd1:    rdata = {{16{val[15]}}, val[15:0]};
                3'd4:    rdata = {24'b0, val[7:0]};
                3'd5:    rdata = {16'b0, val[15:0]};
                default: rdata = val;
            endcase
            lat = 2;
        end else begin
            for (int i = 0; i < size; i++) refMem[addr + i] = wdata[8 * i +: 8];
            base   = {addr[31:2], 2'b00};
            wword  = {refMem[base + 3], refMem[base + 2], refMem[base + 1], refMem[base]};
            writes = 1;
            lat    = (size == 4) ? 2 : 3;
        end
    endtask

    // Issues one request (called at a falling edge), waits for it to be
    // accepted and for its response, and compares everything to the model.
    // With keep set, req_valid stays high after acceptance.
    task automatic applyStimulus(input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input bit keep);
        logic        expFault;
        logic [31:0] expData;
        logic [31:0] expWord;
        int          expLat;
        int          expWrites;
        int          lat;
        int          writes;
        int          waitCnt;
        bit          seen;
        logic        gotFault;
        logic [31:0] gotData;
        logic [31:0] wa;
        logic [31:0] wd;
        refAccess(we, f3, addr, wdata, expFault, expData, expLat, expWrites, expWord);
        ifc.req_valid  = 1'b1;
        ifc.req_we     = we;
        ifc.req_funct3 = f3;
        ifc.req_addr   = addr;
        ifc.req_wdata  = wdata;
        waitCnt = 0;
        while (!ifc.req_ready && waitCnt < 20) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("accept_ready", {31'b0, ifc.req_ready}, 32'd1);
        @(posedge clk);
        lat      = 0;
        writes   = 0;
        seen     = 1'b0;
        gotFault = 1'b0;
        gotData  = 32'h0;
        wa       = 32'h0;
        wd       = 32'h0;
        while (!seen && lat < 10) begin
            @(negedge clk);
            lat++;
            if (!keep) ifc.req_valid = 1'b0;
            if (ifc.mem_we) begin
                writes++;
                wa = ifc.mem_a;
                wd = ifc.mem_wd;
            end
            if (ifc.rsp_valid) begin
                seen     = 1'b1;
                gotFault = ifc.rsp_fault;
                gotData  = ifc.rsp_rdata;
                checkOutput("busy_ready", {31'b0, ifc.req_ready}, 32'd0);
            end
        end
        checkOutput("rsp_seen", {31'b0, seen}, 32'd1);
        checkOutput("latency", 32'(lat), 32'(expLat));
        checkOutput("fault", {31'b0, gotFault}, {31'b0, expFault});
        checkOutput("rdata", gotData, expData);
        checkOutput("writes", 32'(writes), 32'(expWrites));
        if (expWrites != 0) begin
            checkOutput("mem_a", wa, {addr[31:2], 2'b00});
            checkOutput("mem_wd", wd, expWord);
        end
        lastRdata = gotData;
    endtask

    task automatic checkReset(input string pfx);
        checkOutput({pfx, "_ready"},     {31'b0, ifc.req_ready}, 32'd1);
        checkOutput({pfx, "_rsp_valid"}, {31'b0, ifc.rsp_valid}, 32'd0);
        checkOutput({pfx, "_rsp_fault"}, {31'b0, ifc.rsp_fault}, 32'd0);
        checkOutput({pfx, "_rsp_rdata"}, ifc.rsp_rdata, 32'h0);
        checkOutput({pfx, "_mem_a"},     ifc.mem_a, 32'h0);
        checkOutput({pfx, "_mem_wd"},    ifc.mem_wd, 32'h0);
        checkOutput({pfx, "_mem_we"},    {31'b0, ifc.mem_we}, 32'd0);
        checkOutput({pfx, "_mem_rde"},   {31'b0, ifc.mem_rde}, 32'd0);
    endtask

    initial begin
        logic        rWe;
        logic [2:0]  rF3;
        logic [31:0] rAddr;
        int          sel;

        ifc.req_valid  = 1'b0;
        ifc.req_we     = 1'b0;
        ifc.req_funct3 = 3'b000;
        ifc.req_addr   = 32'h0;
        ifc.req_wdata  = 32'h0;
        lastRdata      = 32'h0;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkReset("reset");
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] word store/load and byte RMW");
        applyStimulus(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0);
        applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
        checkOutput("tp_lw", lastRdata, 32'hDEADBEEF);
        applyStimulus(1'b1, 3'b000, 32'h12, 32'h00000055, 1'b0);
        applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
        checkOutput("tp_sb_lw", lastRdata, 32'hDE55BEEF);

        $display("[TB] sign and zero extension");
        applyStimulus(1'b1, 3'b010, 32'h20, 32'h8000FF80, 1'b0);
        applyStimulus(1'b0, 3'b000, 32'h20, 32'h0, 1'b0);
        checkOutput("tp_lb", lastRdata, 32'hFFFFFF80);
        applyStimulus(1'b0, 3'b100, 32'h20, 32'h0, 1'b0);
        checkOutput("tp_lbu", lastRdata, 32'h00000080);
        applyStimulus(1'b0, 3'b001, 32'h22, 32'h0, 1'b0);
        checkOutput("tp_lh", lastRdata, 32'hFFFF8000);
        applyStimulus(1'b0, 3'b101, 32'h22, 32'h0, 1'b0);
        checkOutput("tp_lhu", lastRdata, 32'h00008000);

        $display("[TB] faulting requests");
        applyStimulus(1'b0, 3'b010, 32'h21, 32'h0, 1'b0);
        applyStimulus(1'b1, 3'b001, 32'h23, 32'h0000AAAA, 1'b0);
        applyStimulus(1'b0, 3'b011, 32'h20, 32'h0, 1'b0);
        applyStimulus(1'b1, 3'b100, 32'h20, 32'h11111111, 1'b0);
        applyStimulus(1'b0, 3'b010, 32'(BYTES), 32'h0, 1'b0);
        applyStimulus(1'b0, 3'b010, 32'h20, 32'h0, 1'b0);
        checkOutput("fault_mem_kept", lastRdata, 32'h8000FF80);

        $display("[TB] reset during read-modify-write");
        applyStimulus(1'b1, 3'b010, 32'h30, 32'hCAFEF00D, 1'b0);
        ifc.req_valid  = 1'b1;
        ifc.req_we     = 1'b1;
        ifc.req_funct3 = 3'b001;
        ifc.req_addr   = 32'h30;
        ifc.req_wdata  = 32'h00001234;
        @(negedge clk);
        checkOutput("abort_ready", {31'b0, ifc.req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        ifc.req_valid = 1'b0;
        checkOutput("abort_read_rde", {31'b0, ifc.mem_rde}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkReset("abort");
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("abort_idle_rsp", {31'b0, ifc.rsp_valid}, 32'd0);
        checkOutput("abort_mem", mem[12], 32'hCAFEF00D);
        applyStimulus(1'b0, 3'b010, 32'h30, 32'h0, 1'b0);

        $display("[TB] back-to-back stream");
        applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 1'b1);
        applyStimulus(1'b1, 3'b010, 32'h14, 32'h0BADF00D, 1'b1);
        applyStimulus(1'b0, 3'b010, 32'h14, 32'h0, 1'b0);
        checkOutput("b2b_lw", lastRdata, 32'h0BADF00D);

        $display("[TB] randomized requests");
        for (int n = 0; n < 200; n++) begin
            rWe = 1'($urandom_range(0, 1));
            rF3 = 3'($urandom_range(0, 7));
            sel = int'($urandom_range(0, 9));
            if (sel < 7)      rAddr = 32'($urandom_range(0, 127));
            else if (sel < 9) rAddr = 32'(BYTES) - 32'($urandom_range(1, 8));
            else              rAddr = $urandom;
            applyStimulus(rWe, rF3, rAddr, $urandom, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_dmem_master.md
# lsu_dmem_master

Load/store unit that sits between the core's execute stage and the byte-addressed data memory. Accepts one RISC-V load or store request at a time, drives the data memory's word-wide read and write ports, and returns a sign- or zero-extended load result. Sub-word stores become read-modify-write sequences, because the memory always writes four consecutive bytes. Misaligned, out-of-range and illegal-width requests complete as faults and never touch memory.

## Interface
- MEM_SIZE, 4096: memory depth in 32-bit words; legal byte addresses are 0 .. MEM_SIZE*4-1.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on rising clk.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; the request is accepted when req_valid && req_ready at an edge.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V width code: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; right-aligned for sb/sh.
- rsp_valid  out  1  one-cycle completion pulse; no backpressure.
- rsp_rdata  out  32  load result; 0 for stores and faults.
- rsp_fault  out  1  valid with rsp_valid; 1 = request rejected.
- mem_a  out  32  word-aligned byte address to memory (addr & ~3).
- mem_rde  out  1  memory read enable.
- mem_rd  in  32  combinational memory read data, little-endian (bits [7:0] = byte at mem_a).
- mem_we  out  1  memory write enable; the memory commits at the rising edge while high.
- mem_wd  out  32  memory write data.

## Operation
- States: IDLE, LOAD, READ, WRITE, RESP.
- IDLE: on accept, latch addr, we, funct3 and wdata, then evaluate the fault conditions:
  - funct3 illegal: loads allow {000,001,010,100,101}; stores allow {000,001,010}.
  - h/hu with addr[0] != 0, or w with addr[1:0] != 0.
  - addr + size - 1 > MEM_SIZE*4 - 1.
- IDLE next state: any fault -> RESP with fault=1; load -> LOAD; sw -> WRITE with merge register = wdata; sb/sh -> READ.
- LOAD: mem_rde=1. At the edge, capture the selected lane of mem_rd: byte lane addr[1:0] for b/bu, halfword lane addr[1] for h/hu, whole word for w. Sign-extend for b/h, zero-extend for bu/hu. Next state RESP.
- READ: mem_rde=1. At the edge, merge register = mem_rd with the target lane replaced:
  - sb: byte lane addr[1:0] <- wdata[7:0].
  - sh: halfword lane addr[1] <- wdata[15:0].
  - Next state WRITE.
- WRITE: mem_we=1, mem_wd = merge register. Next state RESP.
- RESP: rsp_valid=1 and rsp_fault as latched. rsp_rdata = load result, or 0 for stores and faults. Next state IDLE.
- Port drive rules:
  - mem_rde = rst_n && state in {LOAD, READ}.
  - mem_we = rst_n && state == WRITE; never high for a faulted request.
  - mem_a is driven from the latched aligned address in every state.
- Reset values: state IDLE, req_ready 1, rsp_valid 0, rsp_fault 0, rsp_rdata 0, mem_a 0, mem_wd 0, mem_we 0, mem_rde 0, and all latches 0.
- Reset mid-operation: rst_n low at any edge forces IDLE. mem_we is gated by rst_n, so a WRITE coinciding with reset does not commit. Any partially completed RMW is abandoned with no response.

## Timing
- Accept at edge T. rsp_valid is high during the cycle after these edges:
  - fault: T+1.
  - load and sw: T+2.
  - sb and sh: T+3.
- req_ready is low from the cycle after accept until IDLE is re-entered; back-to-back requests are accepted at the RESP->IDLE edge + 1, at the earliest.
- Memory write commits at the edge leaving WRITE. A following load observes it.
- Request inputs are ignored outside IDLE.

## Test plan
- sw addr 0x10 data 0xDEADBEEF, then lw 0x10 -> one mem_we pulse with mem_a 0x10 and mem_wd 0xDEADBEEF; load rsp_rdata 0xDEADBEEF; rsp at T+2 both times.
- After the above, sb 0x12 data 0x55, then lw 0x10 -> READ then WRITE with mem_wd 0xDE55BEEF; rsp at T+3; load returns 0xDE55BEEF.
- Word 0x8000FF80 at 0x20: lb 0x20 -> 0xFFFFFF80; lbu 0x20 -> 0x00000080; lh 0x22 -> 0xFFFF8000; lhu 0x22 -> 0x00008000.
- lw 0x21, sh 0x23, funct3 011 load, sb funct3 100, lw MEM_SIZE*4 -> each gives rsp_fault=1, rsp_rdata 0, at T+1; mem_we never asserted; memory unchanged.
- sh 0x30 data 0x1234 with rst_n low on the edge ending READ (WRITE next) -> no mem_we; state IDLE, all outputs at reset values; word at 0x30 unchanged.
- Back-to-back: req_valid held high with lw, sw, lw stream -> each accepted only in IDLE; exactly one rsp_valid per request, in order.
